// File: rtl/mio_bus_responder.sv
// -----------------------------------------------------------------------------
// mio_bus_responder
//
// Responder end of the CPU memory/IO handshake. The multicycle controller
// raises CPU_MIO together with MemRead and/or MemWrite. This block completes
// the request against a synchronous block RAM or a small IO register file,
// then returns a single-cycle MIO_ready. The bus carries whole words only.
// The CPU builds halfword accesses itself from full-word reads and writes.
//
// Handshake: a request is taken on the first rising edge where the FSM is in
// IDLE and CPU_MIO && (MemRead || MemWrite) holds. Address, data and direction
// are captured on that edge. Request inputs are ignored until the FSM returns
// to IDLE. MIO_ready is high for exactly one cycle (the DONE state) for each
// request taken. The cycle after DONE is always IDLE, so a CPU that holds
// CPU_MIO high gets one ack per request, never a repeated ack for the same
// request.
//
// Address map (addr_bus[31:28]):
//   4'hF : IO. addr_bus[3:2] selects the register:
//          0 = LED register (RW), 1 = sw_in (RO), 2 = counter (RW), 3 = zero.
//   4'hE : unmapped. Reads return 0, writes are dropped, the request is acked.
//   other: RAM word addr_bus[RAM_AW+1:2]. The upper address bits alias.
//
// Latency, from the accepting edge to MIO_ready high:
//   IO/unmapped = 1 cycle, RAM write = 2 cycles, RAM read = RAM_LAT+1 cycles.
//
// Configuration macro: MIO_COUNTER_EN
//   defined   : a free-running 32-bit counter sits at IO offset 8. A write
//               loads it, and the load takes priority over that cycle's
//               increment.
//   undefined : no counter is built. Offset 8 reads 0, and writes to it are
//               acked and dropped.
//
// Parameters:
//   RAM_AW  : RAM word-address width
//   RAM_LAT : cycles from ram_addr driven to ram_dout sampled (>= 1)
//   LED_W   : width of led_out
//   SW_W    : width of sw_in
//
// Ports:
//   clk        : system clock
//   reset      : synchronous, active-high reset
//   CPU_MIO    : request valid, held by the CPU until it sees MIO_ready
//   MemRead    : read request
//   MemWrite   : write request (wins if MemRead is also set)
//   addr_bus   : byte address, [1:0] ignored
//   Data_in    : write data from the CPU
//   Data_out   : read data to the CPU, holds until the next read completes
//   MIO_ready  : one-cycle completion strobe
//   ram_addr   : RAM word address (latched at accept)
//   ram_din    : RAM write data (latched at accept)
//   ram_we     : RAM write enable, one cycle per RAM write
//   ram_dout   : RAM read data
//   led_out    : LED register
//   sw_in      : switch inputs, already synchronised
//   fsm_state  : current FSM state (IDLE=0, RAM_RD=1, RAM_WR=2, DONE=3)
// -----------------------------------------------------------------------------
module mio_bus_responder #(
    parameter int RAM_AW  = 10,
    parameter int RAM_LAT = 2,
    parameter int LED_W   = 8,
    parameter int SW_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CPU_MIO,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       addr_bus,
    input  logic [31:0]       Data_in,
    output logic [31:0]       Data_out,
    output logic              MIO_ready,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic              ram_we,
    input  logic [31:0]       ram_dout,
    output logic [LED_W-1:0]  led_out,
    input  logic [SW_W-1:0]   sw_in,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAM_RD = 2'd1,
        RAM_WR = 2'd2,
        DONE   = 2'd3
    } state_t;

    // The wait counter must be able to hold RAM_LAT-1. Sizing it for RAM_LAT
    // keeps the width at least 1 when RAM_LAT is 1.
    localparam int WAIT_W = $clog2(RAM_LAT + 1);

    localparam logic [1:0] IO_LED = 2'd0;
    localparam logic [1:0] IO_SW  = 2'd1;
    localparam logic [1:0] IO_CNT = 2'd2;

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;

    // ------------------------------------------------------------------
    // Request decode. These signals are only meaningful in IDLE. In every
    // other state the FSM works from the latched ram_addr/ram_din.
    // ------------------------------------------------------------------
    logic       accept;
    logic       req_io;
    logic       req_unmapped;
    logic       req_ram;
    logic [1:0] io_sel;
    logic       rd_last;

    assign accept       = (state == IDLE) && CPU_MIO && (MemRead || MemWrite);
    assign req_io       = (addr_bus[31:28] == 4'hF);
    assign req_unmapped = (addr_bus[31:28] == 4'hE);
    assign req_ram      = !req_io && !req_unmapped;
    assign io_sel       = addr_bus[3:2];
    assign rd_last      = (wait_cnt == WAIT_W'(RAM_LAT - 1));

    // Address bits outside the decode simply alias.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_bus[27:RAM_AW+2], addr_bus[1:0]};

    // ------------------------------------------------------------------
    // Optional free-running counter at IO offset 8.
    // ------------------------------------------------------------------
    logic [31:0] counter_rdata;

`ifdef MIO_COUNTER_EN
    logic [31:0] counter;

    always_ff @(posedge clk) begin
        if (reset) begin
            counter <= 32'd0;
        end else if (accept && req_io && MemWrite && (io_sel == IO_CNT)) begin
            counter <= Data_in;
        end else begin
            counter <= counter + 32'd1;
        end
    end

    assign counter_rdata = counter;
`else
    assign counter_rdata = 32'd0;
`endif

    // ------------------------------------------------------------------
    // IO read mux. Narrow registers are zero-extended. Unmapped addresses
    // fall through to zero.
    // ------------------------------------------------------------------
    logic [31:0] io_rdata;

    always_comb begin
        io_rdata = 32'd0;
        if (req_io) begin
            case (io_sel)
                IO_LED:  io_rdata[LED_W-1:0] = led_out;
                IO_SW:   io_rdata[SW_W-1:0]  = sw_in;
                IO_CNT:  io_rdata            = counter_rdata;
                default: io_rdata            = 32'd0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic. IO and unmapped accesses finish on the accept
    // edge, so they go straight to DONE.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!req_ram) begin
                        state_next = DONE;
                    end else if (MemWrite) begin
                        state_next = RAM_WR;
                    end else begin
                        state_next = RAM_RD;
                    end
                end
            end
            RAM_RD: begin
                if (rd_last) begin
                    state_next = DONE;
                end
            end
            RAM_WR:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign MIO_ready = (state == DONE);
    assign fsm_state = state;

    // ------------------------------------------------------------------
    // Datapath.
    // ram_addr and ram_din act as the request latches. ram_we is set on the
    // accept edge of a RAM write, so it is high exactly during RAM_WR.
    // In RAM_RD the RAM sees the latched address from the first cycle.
    // ram_dout is sampled on the edge that ends the RAM_LAT-th cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            Data_out <= 32'd0;
            ram_addr <= '0;
            ram_din  <= 32'd0;
            ram_we   <= 1'b0;
            led_out  <= '0;
            wait_cnt <= '0;
        end else begin
            ram_we <= 1'b0;

            if (accept) begin
                wait_cnt <= '0;
                if (req_ram) begin
                    ram_addr <= addr_bus[RAM_AW+1:2];
                    if (MemWrite) begin
                        ram_din <= Data_in;
                        ram_we  <= 1'b1;
                    end
                end else if (!MemWrite) begin
                    Data_out <= io_rdata;
                end

                if (req_io && MemWrite && (io_sel == IO_LED)) begin
                    led_out <= Data_in[LED_W-1:0];
                end
            end

            if (state == RAM_RD) begin
                if (rd_last) begin
                    Data_out <= ram_dout;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end
        end
    end

endmodule
